// File: rtl/sprite_line_selector_pkg.sv
// Shared types and constants for the per-scanline sprite selection stage.
//   sprite_conf_t : one OAM sprite configuration as delivered by oam_scanner
//   slot_entry_t  : one selected sprite plus the row offset into that sprite
//   sel_state_t   : selector FSM states
package sprite_line_selector_pkg;

  localparam int MAX_SPRITES = 64;  // OAM entries scanned per line
  localparam int SPR_SLOTS   = 16;  // default number of sprite slots per line
  localparam int SPR_OFS_W   = 6;   // stored line offset width (sprites up to 64 rows)

  // y is the top row, h selects the height as (h+1)*8 rows.
  typedef struct packed {
    logic [7:0] y;
    logic [2:0] h;
    logic [7:0] x;
    logic [7:0] tile;
    logic [4:0] attr;
  } sprite_conf_t;

  typedef struct packed {
    sprite_conf_t         conf;
    logic [SPR_OFS_W-1:0] ofs;
  } slot_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DONE
  } sel_state_t;

endpackage

// File: rtl/sprite_line_selector_slot_buf.sv
// Slot buffer for selected sprites.
//   clock  : system clock
//   we     : write enable, waddr/wdata written on the rising edge
//   raddr  : read address, rdata is a combinational read of that slot
// Contents are not reset; the selector's slot count defines which slots are valid.
module sprite_line_selector_slot_buf
  import sprite_line_selector_pkg::*;
#(
  parameter int SLOTS = SPR_SLOTS,
  localparam int IW   = $clog2(SLOTS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  slot_entry_t   wdata,
  input  logic [IW-1:0] raddr,
  output slot_entry_t   rdata
);

  slot_entry_t mem [SLOTS];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_line_selector.sv
// Per-scanline sprite selector, downstream of oam_scanner.
// On line_start it clears the scanner, then pulls in-range sprite configs
// via conf_req/conf_ack and stores up to SLOTS of them (with their row
// offset) in OAM order. line_done signals the buffer is ready to read.
//   clock, reset_l        : clock, asynchronous active-low reset
//   line_start, row       : start pulse and current scanline
//   scan_clear, conf_req  : scanner clear pulse and config request
//   conf_ack, conf_exists : scanner ack pulse and "entries remain" flag
//   oam_avail, oam_data   : OAM read completion strobe and config bus
//   slot_count, slot_idx, slot_data : valid slot count and read port
//   line_done, truncated  : selection complete, slots filled early
module sprite_line_selector
  import sprite_line_selector_pkg::*;
#(
  parameter int SLOTS = SPR_SLOTS,
  localparam int IW   = $clog2(SLOTS),
  localparam int CW   = IW + 1
) (
  input  logic          clock,
  input  logic          reset_l,
  input  logic          line_start,
  input  logic [7:0]    row,
  output logic          scan_clear,
  output logic          conf_req,
  input  logic          conf_ack,
  input  logic          conf_exists,
  input  logic          oam_avail,
  input  sprite_conf_t  oam_data,
  output logic [CW-1:0] slot_count,
  input  logic [IW-1:0] slot_idx,
  output slot_entry_t   slot_data,
  output logic          line_done,
  output logic          truncated
);

  sel_state_t     state;
  logic [CW-1:0]  count;
  logic           pend;
  logic           full;
  logic [CW:0]    reserved;
  logic           room;
  logic           we;
  slot_entry_t    wdata;

  assign full     = (count == CW'(SLOTS));
  // A pending read holds a slot in reserve, so an ack can never find the buffer full.
  assign reserved = {1'b0, count} + {{CW{1'b0}}, pend};
  assign room     = (reserved < (CW + 1)'(SLOTS));
  assign conf_req = (state == ST_SCAN) & conf_exists & room;

  // Acks outside SCAN (e.g. a read in flight when the line restarted) are dropped.
  assign we          = (state == ST_SCAN) & conf_ack & ~full;
  assign wdata.conf  = oam_data;
  assign wdata.ofs   = SPR_OFS_W'(row - oam_data.y);
  assign slot_count  = count;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state      <= ST_IDLE;
      count      <= '0;
      pend       <= 1'b0;
      scan_clear <= 1'b0;
      line_done  <= 1'b0;
      truncated  <= 1'b0;
    end else begin
      scan_clear <= 1'b0;
      if (line_start) begin
        // Restart from any state; the scanner flushes its own in-flight read.
        state      <= ST_CLEAR;
        scan_clear <= 1'b1;
        count      <= '0;
        pend       <= 1'b0;
        line_done  <= 1'b0;
        truncated  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE:  ;
          ST_CLEAR: state <= ST_SCAN;
          ST_SCAN: begin
            if (we) count <= count + CW'(1);
            // The scanner never starts a read in the cycle it completes one.
            if (oam_avail)           pend <= 1'b0;
            else if (conf_req & ~pend) pend <= 1'b1;
            if (~pend & (~conf_exists | full)) begin
              state     <= ST_DONE;
              line_done <= 1'b1;
              truncated <= full & conf_exists;
            end
          end
          ST_DONE:  ;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  sprite_line_selector_slot_buf #(.SLOTS(SLOTS)) u_slot_buf (
    .clock (clock),
    .we    (we),
    .waddr (count[IW-1:0]),
    .wdata (wdata),
    .raddr (slot_idx),
    .rdata (slot_data)
  );

endmodule
